// File: rtl/mem_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_ctrl: arbitrates fetch and load/store onto one 8-bit RAM/IO    |
// | bus, serialising little-endian 1/2/4-byte accesses.                |
// | Revision: 1.0                                                      |
// +-------------------------------------------------------------------+
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        ls_req_in,
  input  logic        ls_wr_in,
  input  logic [1:0]  ls_size_in,
  input  logic [31:0] ls_addr_in,
  input  logic [31:0] ls_wdata_in,
  output logic        ls_done_out,
  output logic [31:0] ls_rdata_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] base_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [2:0]  len_q;
  logic [2:0]  cnt_q;
  logic        gap_q;

  logic        w_idle;
  logic        w_accept;
  logic        w_store_go;
  logic        w_io;
  logic        w_stall;
  logic        w_last;
  logic [2:0]  w_ls_len;
  logic [2:0]  w_len;
  logic [2:0]  w_cnt;
  logic [2:0]  w_rd_k;
  logic [1:0]  w_rd_idx;
  logic [31:0] w_base;
  logic [31:0] w_wdata;
  logic [31:0] w_addr;
  logic [31:0] w_rd_word;
  logic [7:0]  w_byte;

  // Store issue is shared between the accepting edge (IDLE) and STORE.
  always_comb begin
    case (ls_size_in)
      2'd0:    w_ls_len = 3'd1;
      2'd1:    w_ls_len = 3'd2;
      default: w_ls_len = 3'd4;
    endcase
    w_idle     = (state_q == IDLE);
    w_accept   = w_idle && !clr_in && !if_done_out && !ls_done_out &&
                 (ls_req_in || if_req_in);
    w_store_go = (w_accept && ls_req_in && ls_wr_in) || (state_q == STORE && !gap_q);
    w_len      = w_idle ? w_ls_len : len_q;
    w_cnt      = w_idle ? 3'd0 : cnt_q;
    w_base     = w_idle ? ls_addr_in : base_q;
    w_wdata    = w_idle ? ls_wdata_in : wdata_q;
    w_addr     = w_base + {29'd0, w_cnt};
    w_byte     = w_wdata[{w_cnt[1:0], 3'b000} +: 8];
    w_io       = (w_addr[17:16] == 2'b11);
    w_stall    = w_io && io_buffer_full;
    w_last     = ((w_cnt + 3'd1) == w_len);
    w_rd_k     = cnt_q + 3'd1;
    w_rd_idx   = 2'(w_rd_k - 3'd2);
    w_rd_word  = buf_q;
    w_rd_word[{w_rd_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      base_q       <= 32'd0;
      wdata_q      <= 32'd0;
      buf_q        <= 32'd0;
      len_q        <= 3'd0;
      cnt_q        <= 3'd0;
      gap_q        <= 1'b0;
      mem_a        <= 32'd0;
      mem_dout     <= 8'd0;
      mem_wr       <= 1'b0;
      if_done_out  <= 1'b0;
      if_data_out  <= 32'd0;
      ls_done_out  <= 1'b0;
      ls_rdata_out <= 32'd0;
    end else if (rdy_in) begin
      if_done_out <= 1'b0;
      ls_done_out <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_a    <= 32'd0;
          mem_dout <= 8'd0;
          mem_wr   <= 1'b0;
          cnt_q    <= 3'd0;
          gap_q    <= 1'b0;
          buf_q    <= 32'd0;
          if (w_accept) begin
            if (ls_req_in) begin
              base_q  <= ls_addr_in;
              wdata_q <= ls_wdata_in;
              len_q   <= w_ls_len;
              mem_a   <= ls_addr_in;
              state_q <= ls_wr_in ? STORE : LOAD;
            end else begin
              base_q  <= if_addr_in;
              len_q   <= 3'd4;
              mem_a   <= if_addr_in;
              state_q <= FETCH;
            end
          end
        end
        FETCH, LOAD: begin
          if (clr_in) begin
            state_q <= IDLE;
            mem_a   <= 32'd0;
            mem_wr  <= 1'b0;
          end else begin
            cnt_q <= w_rd_k;
            if (w_rd_k < len_q) begin
              mem_a <= base_q + {29'd0, w_rd_k};
            end
            // mem_din lags the address by two edges
            if (w_rd_k >= 3'd2) begin
              buf_q <= w_rd_word;
            end
            if (w_rd_k == (len_q + 3'd1)) begin
              state_q <= IDLE;
              mem_a   <= 32'd0;
              if (state_q == FETCH) begin
                if_data_out <= w_rd_word;
                if_done_out <= 1'b1;
              end else begin
                ls_rdata_out <= w_rd_word;
                ls_done_out  <= 1'b1;
              end
            end
          end
        end
        STORE: begin
          if (gap_q) begin
            mem_wr <= 1'b0;
            gap_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (w_store_go) begin
        mem_a    <= w_addr;
        mem_dout <= w_byte;
        mem_wr   <= !w_stall;
        if (!w_stall) begin
          cnt_q <= w_cnt + 3'd1;
          gap_q <= w_io;
          if (w_last) begin
            ls_done_out <= 1'b1;
            state_q     <= IDLE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_mem_ctrl: directed self-checking bench for mem_ctrl.            |
// | Revision: 1.0                                                      |
// +-------------------------------------------------------------------+
module tb_mem_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, clr, io_full;
  logic        if_req, ls_req, ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a, if_data, ls_rdata;
  logic        mem_wr, if_done, ls_done;

  mem_ctrl dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clr_in(clr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_full),
    .if_req_in(if_req), .if_addr_in(if_addr), .if_done_out(if_done), .if_data_out(if_data),
    .ls_req_in(ls_req), .ls_wr_in(ls_wr), .ls_size_in(ls_size), .ls_addr_in(ls_addr),
    .ls_wdata_in(ls_wdata), .ls_done_out(ls_done), .ls_rdata_out(ls_rdata)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is_store;
    logic [31:0] data;
  } ls_exp_t;

  logic [31:0] exp_if_q[$];
  ls_exp_t     exp_ls_q[$];
  logic [39:0] exp_wr_q[$];

  logic full_at_edge, rdy_at_edge;
  logic prev_if_done, prev_ls_done, prev_io_wr;
  bit   tb_done;

  // RAM contents are a pure function of address; the RAM shares the global enable.
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    case (a)
      32'h4:   return 8'h13;
      32'h5:   return 8'h05;
      32'h6:   return 8'h10;
      32'h7:   return 8'h00;
      default: return a[7:0] * 8'd3 + 8'h21;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
    logic [31:0] d;
    d = 32'd0;
    for (int k = 0; k < n; k++) d[8*k +: 8] = byte_at(a + 32'(k));
    return d;
  endfunction

  always @(posedge clk) begin
    full_at_edge <= io_full;
    rdy_at_edge  <= rdy;
    if (rdy) mem_din <= byte_at(mem_a);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_cycle();
    logic [31:0] d;
    ls_exp_t     e;
    logic [39:0] w;
    if (!rdy_at_edge) return;
    if (if_done) begin
      chk("if_done single cycle", 32'(prev_if_done), 32'd0);
      if (exp_if_q.size() == 0) chk("if_done unexpected", 32'(if_done), 32'd0);
      else begin
        d = exp_if_q.pop_front();
        chk("if_data vs model", if_data, d);
      end
    end
    if (ls_done) begin
      chk("ls_done single cycle", 32'(prev_ls_done), 32'd0);
      if (exp_ls_q.size() == 0) chk("ls_done unexpected", 32'(ls_done), 32'd0);
      else begin
        e = exp_ls_q.pop_front();
        if (!e.is_store) chk("ls_rdata vs model", ls_rdata, e.data);
      end
    end
    if (mem_wr) begin
      if (exp_wr_q.size() == 0) chk("mem_wr unexpected", 32'(mem_wr), 32'd0);
      else begin
        w = exp_wr_q.pop_front();
        chk("write addr vs model", mem_a, w[39:8]);
        chk("write byte vs model", 32'(mem_dout), 32'(w[7:0]));
      end
      if (mem_a[17:16] == 2'b11) begin
        chk("io write while full", 32'(full_at_edge), 32'd0);
        chk("io write without idle gap", 32'(prev_io_wr), 32'd0);
      end
    end
    prev_if_done = if_done;
    prev_ls_done = ls_done;
    prev_io_wr   = mem_wr && (mem_a[17:16] == 2'b11);
  endtask

  task automatic wait_done(input bit is_if, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (is_if ? if_done : ls_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] lit,
                           input int exp_lat, input string name);
    int lat;
    exp_if_q.push_back(model_word(addr, 4));
    if_addr = addr;
    if_req  = 1'b1;
    wait_done(1'b1, lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " data"}, if_data, lit);
    if_req = 1'b0;
    tick();
    chk({name, " bus idle after"}, mem_a, 32'd0);
  endtask

  task automatic run_ls(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] lit,
                        input int exp_lat, input string name);
    int n, lat;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (wr) begin
      for (int k = 0; k < n; k++) exp_wr_q.push_back({addr + 32'(k), wdata[8*k +: 8]});
      exp_ls_q.push_back({1'b1, 32'd0});
    end else begin
      exp_ls_q.push_back({1'b0, model_word(addr, n)});
    end
    ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
    wait_done(1'b0, lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (!wr) chk({name, " data"}, ls_rdata, lit);
    ls_req = 1'b0;
    tick();
    chk({name, " mem_wr idle after"}, 32'(mem_wr), 32'd0);
    chk({name, " mem_a idle after"}, mem_a, 32'd0);
  endtask

  task automatic run_tests();
    int lat;
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    repeat (3) tick();
    chk("reset mem_a", mem_a, 32'd0);
    chk("reset mem_dout", 32'(mem_dout), 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset if_done", 32'(if_done), 32'd0);
    chk("reset ls_done", 32'(ls_done), 32'd0);
    chk("reset if_data", if_data, 32'd0);
    chk("reset ls_rdata", ls_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // Word fetch at 0x4: address walk, latency 6, known instruction.
    exp_if_q.push_back(model_word(32'h4, 4));
    if_addr = 32'h4; if_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i <= 4) chk("fetch0 mem_a walk", mem_a, 32'h4 + 32'(i - 1));
      if (i < 6) chk("fetch0 early done", 32'(if_done), 32'd0);
    end
    chk("fetch0 done at 6", 32'(if_done), 32'd1);
    chk("fetch0 data", if_data, 32'h00100513);
    if_req = 1'b0;
    tick();
    chk("fetch0 done one cycle", 32'(if_done), 32'd0);
    chk("fetch0 data held", if_data, 32'h00100513);

    run_ls(1'b0, 2'd0, 32'h101, 32'd0, 32'h00000024, 3, "byte load");
    run_ls(1'b0, 2'd1, 32'h102, 32'd0, 32'h00002A27, 4, "half load");
    run_ls(1'b0, 2'd3, 32'h100, 32'd0, 32'h2A272421, 6, "size3 load");

    // Simultaneous requests: LS first, then fetch after the bubble.
    exp_ls_q.push_back({1'b0, model_word(32'h100, 4)});
    exp_if_q.push_back(model_word(32'hC, 4));
    ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h100; ls_req = 1'b1;
    if_addr = 32'hC; if_req = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i <= 4) chk("arb ls addr", mem_a, 32'h100 + 32'(i - 1));
      if (i >= 8 && i <= 11) chk("arb if addr", mem_a, 32'hC + 32'(i - 8));
      if (i == 6) begin
        chk("arb ls_done", 32'(ls_done), 32'd1);
        chk("arb ls data", ls_rdata, 32'h2A272421);
        ls_req = 1'b0;
      end
      if (i == 7) chk("arb bubble", mem_a, 32'd0);
    end
    chk("arb if_done", 32'(if_done), 32'd1);
    chk("arb if data", if_data, 32'h4E4B4845);
    if_req = 1'b0;
    tick();

    // IO byte store held off by a full UART buffer.
    exp_wr_q.push_back({32'h30000, 8'h41});
    exp_ls_q.push_back({1'b1, 32'd0});
    io_full = 1'b1;
    ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41; ls_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("io stall mem_wr", 32'(mem_wr), 32'd0);
    end
    io_full = 1'b0;
    tick();
    chk("io write mem_wr", 32'(mem_wr), 32'd1);
    chk("io write mem_a", mem_a, 32'h30000);
    chk("io write mem_dout", 32'(mem_dout), 32'h41);
    chk("io write ls_done", 32'(ls_done), 32'd1);
    ls_req = 1'b0;
    tick();
    chk("io write idle after", 32'(mem_wr), 32'd0);

    // Half store 0xBEEF at 0x200.
    exp_wr_q.push_back({32'h200, 8'hEF});
    exp_wr_q.push_back({32'h201, 8'hBE});
    exp_ls_q.push_back({1'b1, 32'd0});
    ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h200; ls_wdata = 32'h1234BEEF; ls_req = 1'b1;
    tick();
    chk("half st b0 addr", mem_a, 32'h200);
    chk("half st b0 data", 32'(mem_dout), 32'hEF);
    chk("half st b0 no done", 32'(ls_done), 32'd0);
    tick();
    chk("half st b1 addr", mem_a, 32'h201);
    chk("half st b1 data", 32'(mem_dout), 32'hBE);
    chk("half st b1 done", 32'(ls_done), 32'd1);
    ls_req = 1'b0;
    tick();
    chk("half st wr low after", 32'(mem_wr), 32'd0);

    run_ls(1'b1, 2'd1, 32'h30010, 32'h00005A3C, 32'd0, 3, "io half store");

    // Flush during fetch byte 2, then a clean fetch of 0x8.
    if_addr = 32'h10; if_req = 1'b1;
    repeat (3) tick();
    chk("flush byte2 on bus", mem_a, 32'h12);
    clr = 1'b1; if_req = 1'b0;
    tick();
    clr = 1'b0;
    chk("flush mem_a idle", mem_a, 32'd0);
    chk("flush mem_wr idle", 32'(mem_wr), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("flush no if_done", 32'(if_done), 32'd0);
    end
    run_fetch(32'h8, 32'h423F3C39, 6, "post-flush fetch");

    // clr during a store is ignored.
    exp_wr_q.push_back({32'h210, 8'h22});
    exp_wr_q.push_back({32'h211, 8'h11});
    exp_ls_q.push_back({1'b1, 32'd0});
    ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h210; ls_wdata = 32'h1122; ls_req = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    chk("store ignores clr done", 32'(ls_done), 32'd1);
    chk("store ignores clr addr", mem_a, 32'h211);
    clr = 1'b0; ls_req = 1'b0;
    tick();

    // Five-cycle rdy pause inside a word load.
    exp_ls_q.push_back({1'b0, model_word(32'h104, 4)});
    ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h104; ls_req = 1'b1;
    repeat (2) tick();
    chk("pause pre addr", mem_a, 32'h105);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause frozen addr", mem_a, 32'h105);
      chk("pause no done", 32'(ls_done), 32'd0);
    end
    rdy = 1'b1;
    wait_done(1'b0, lat);
    chk("pause remaining latency", 32'(lat), 32'd4);
    chk("pause load data", ls_rdata, 32'h3633302D);
    ls_req = 1'b0;
    tick();

    // Reset aborts a partial word store.
    exp_wr_q.push_back({32'h300, 8'h44});
    exp_wr_q.push_back({32'h301, 8'h33});
    ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'h11223344; ls_req = 1'b1;
    repeat (2) tick();
    rst = 1'b1; ls_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("reset abort mem_wr", 32'(mem_wr), 32'd0);
    chk("reset abort mem_a", mem_a, 32'd0);
    chk("reset abort ls_done", 32'(ls_done), 32'd0);
    repeat (3) tick();
    chk("reset abort no resume", 32'(mem_wr), 32'd0);

    chk("fetch expectations drained", 32'(exp_if_q.size()), 32'd0);
    chk("ls expectations drained", 32'(exp_ls_q.size()), 32'd0);
  endtask

  initial begin
    tb_done      = 1'b0;
    prev_if_done = 1'b0;
    prev_ls_done = 1'b0;
    prev_io_wr   = 1'b0;
    fork
      begin
        while (!tb_done) begin
          @(negedge clk);
          monitor_cycle();
        end
      end
      begin
        run_tests();
        tb_done = 1'b1;
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
